// File: rtl/softmax_pkg.sv
// Shared softmax datapath types and constants: accumulator FSM states,
// FP16 constants and adder status bit positions.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  localparam int unsigned ST_ZERO    = 0;
  localparam int unsigned ST_INF     = 1;
  localparam int unsigned ST_INVALID = 2;
  localparam int unsigned ST_TINY    = 3;
  localparam int unsigned ST_HUGE    = 4;
  localparam int unsigned ST_INEXACT = 5;

endpackage

// File: rtl/exp_sum_acc_fpadd.sv
// Combinational FP16 adder, round-to-nearest-even, IEEE special values,
// DW_fp_add-style status byte (sig_width 10, exp_width 5, ieee_compliance 1).
module exp_sum_acc_fpadd
  import softmax_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] z_o,
  output logic [7:0]  status_o
);

  localparam int unsigned MW = 41;

  logic          sa, sb;
  logic [4:0]    ea, eb;
  logic [9:0]    fa, fb;
  logic          nan_a, nan_b, inf_a, inf_b;
  logic [MW-1:0] ia, ib, mag;
  logic          s;
  logic [5:0]    p;
  logic [5:0]    shift;
  logic [9:0]    mant;
  logic          rbit, sticky, rup;
  logic [15:0]   val;

  assign {sa, ea, fa} = a_i;
  assign {sb, eb, fb} = b_i;
  assign nan_a = (ea == 5'h1F) && (fa != '0);
  assign nan_b = (eb == 5'h1F) && (fb != '0);
  assign inf_a = (ea == 5'h1F) && (fa == '0);
  assign inf_b = (eb == 5'h1F) && (fb == '0);

  // Any finite FP16 is an integer multiple of 2^-24; two of them sum exactly in 41 bits.
  function automatic logic [MW-1:0] to_fixed(input logic [4:0] e, input logic [9:0] f);
    logic [MW-1:0] m;
    m = MW'({(e != '0), f});
    return (e == '0) ? m : (m << (e - 5'd1));
  endfunction

  always_comb begin
    ia = to_fixed(ea, fa);
    ib = to_fixed(eb, fb);
    if (sa == sb) begin
      mag = ia + ib;
      s   = sa;
    end else if (ia >= ib) begin
      mag = ia - ib;
      s   = sa;
    end else begin
      mag = ib - ia;
      s   = sb;
    end

    p = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (mag[i]) p = 6'(i);
    end

    shift  = (p > 6'd10) ? (p - 6'd10) : 6'd0;
    mant   = 10'(mag >> shift);
    rbit   = 1'b0;
    sticky = 1'b0;
    if (shift != '0) begin
      rbit   = mag[shift - 6'd1];
      sticky = |(mag & ((MW'(1) << (shift - 6'd1)) - MW'(1)));
    end
    rup = rbit & (sticky | mant[0]);
    // Rounding carry ripples from fraction into exponent, and into 31 on overflow.
    val = {shift + 6'd1, mant} + 16'(rup);

    z_o      = '0;
    status_o = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      z_o                  = FP16_QNAN;
      status_o[ST_INVALID] = 1'b1;
    end else if (inf_a || inf_b) begin
      z_o              = inf_a ? a_i : b_i;
      status_o[ST_INF] = 1'b1;
    end else if (mag == '0) begin
      z_o               = {sa & sb, 15'h0000};
      status_o[ST_ZERO] = 1'b1;
    end else if (p <= 6'd10) begin
      z_o               = {s, mag[14:0]};
      status_o[ST_TINY] = ~mag[10];
    end else if (val >= FP16_INF) begin
      z_o                  = {s, FP16_INF[14:0]};
      status_o[ST_INF]     = 1'b1;
      status_o[ST_HUGE]    = 1'b1;
      status_o[ST_INEXACT] = 1'b1;
    end else begin
      z_o                  = {s, val[14:0]};
      status_o[ST_INEXACT] = rbit | sticky;
    end
  end

endmodule

// File: rtl/exp_sum_acc.sv
// Streaming FP16 vector accumulator: sums one in_last-delimited vector and
// holds sum, count and sticky adder status until the divider takes them.
module exp_sum_acc
  import softmax_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic [7:0]       out_status,
  output logic             out_len_err
);

  acc_state_t       state_q;
  logic [15:0]      acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       stat_q;
  logic             len_err_q;

  logic [15:0]      acc_d;
  logic [7:0]       add_stat;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             at_max;

  exp_sum_acc_fpadd u_add (
    .a_i      (acc_q),
    .b_i      (in_data),
    .z_o      (acc_d),
    .status_o (add_stat)
  );

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign cnt_d    = cnt_q + 1'b1;
  assign at_max   = (cnt_d == CNT_W'(MAX_LEN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= FP16_ZERO;
      cnt_q     <= '0;
      stat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            stat_q <= stat_q | add_stat;
            if (in_last) begin
              state_q <= HOLD;
            end else if ((state_q == ACCUM) && at_max) begin
              state_q   <= HOLD;
              len_err_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q   <= IDLE;
            acc_q     <= FP16_ZERO;
            cnt_q     <= '0;
            stat_q    <= '0;
            len_err_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = (state_q == HOLD);
  assign out_sum     = acc_q;
  assign out_count   = cnt_q;
  assign out_status  = stat_q;
  assign out_len_err = len_err_q;

endmodule

// File: tb/tb_exp_sum_acc.sv
// Self-checking bench for exp_sum_acc against a real-arithmetic FP16 model.
module tb_exp_sum_acc;
  import softmax_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_len_err;
  logic [15:0] in_data, out_sum;
  logic [10:0] out_count;
  logic [7:0]  out_status;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_len_err;
  logic [15:0] b_in_data, b_out_sum;
  logic [2:0]  b_out_count;
  logic [7:0]  b_out_status;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  exp_sum_acc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_status(out_status),
    .out_len_err(out_len_err)
  );

  exp_sum_acc #(.MAX_LEN(4), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_status(b_out_status),
    .out_len_err(b_out_len_err)
  );

  // ---------------- reference model ----------------
  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_val(input logic [15:0] h);
    int  e;
    int  f;
    real m;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0) m = real'(f) * pow2(-24);
    else m = real'(1024 + f) * pow2(e - 25);
    return h[15] ? -m : m;
  endfunction

  task automatic ref_add(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] z, output logic [7:0] st);
    real x, ax, sc, rem;
    int  e, fl;
    logic sg;
    st = '0;
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) begin
      z = (a[14:10] == 5'h1F) ? a : b;
      st[1] = 1'b1;
      return;
    end
    x = fp16_val(a) + fp16_val(b);
    if (x == 0.0) begin
      z = {a[15] & b[15], 15'd0};
      st[0] = 1'b1;
      return;
    end
    sg = (x < 0.0);
    ax = sg ? -x : x;
    if (ax < pow2(-14)) begin
      z = {sg, 5'd0, 10'($rtoi(ax * pow2(24)))};
      st[3] = 1'b1;
      return;
    end
    e = -14;
    while (ax >= pow2(e + 1)) e++;
    sc  = ax * pow2(10 - e);
    fl  = $rtoi(sc);
    rem = sc - real'(fl);
    if (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1)) fl++;
    if (fl == 2048) begin
      fl = 1024;
      e++;
    end
    if (rem != 0.0) st[5] = 1'b1;
    if (e + 15 >= 31) begin
      z = {sg, 5'h1F, 10'd0};
      st[1] = 1'b1;
      st[4] = 1'b1;
      st[5] = 1'b1;
    end else begin
      z = {sg, 5'(e + 15), 10'(fl - 1024)};
    end
  endtask

  function automatic logic [15:0] rand_fp16();
    logic [15:0] h;
    h[15]    = ($urandom_range(0, 3) == 0);
    h[14:10] = 5'($urandom_range(0, 29));
    h[9:0]   = 10'($urandom);
    return h;
  endfunction

  // ---------------- drivers ----------------
  task automatic push_beat(input logic [15:0] d, input logic l, output int unsigned stalls);
    stalls = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && stalls < 50) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL push_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if ({out_sum, out_count, out_status, out_len_err} !== '0)
      $display("FAIL reset_outputs: got %h/%0d/%h/%b want 0", out_sum, out_count, out_status, out_len_err);
    else n_pass++;
  endtask

  task automatic test_four_ones();
    int unsigned st;
    for (int i = 0; i < 4; i++) push_beat(FP16_ONE, i == 3, st);
    n_total++; if (out_valid !== 1'b1) $display("FAIL four_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL four_in_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (out_sum !== 16'h4400) $display("FAIL four_sum: got %h want 4400", out_sum); else n_pass++;
    n_total++; if (out_count !== 11'd4) $display("FAIL four_count: got %0d want 4", out_count); else n_pass++;
    n_total++; if (out_status[5] !== 1'b0) $display("FAIL four_inexact: got %b want 0", out_status[5]); else n_pass++;
    take_result();
  endtask

  task automatic test_single();
    int unsigned st;
    push_beat(16'h3E00, 1'b1, st);
    n_total++; if (out_sum !== 16'h3E00 || out_count !== 11'd1)
      $display("FAIL single_sum: got %h/%0d want 3e00/1", out_sum, out_count);
    else n_pass++;
    take_result();
    push_beat(16'h8000, 1'b1, st);
    n_total++; if (out_sum !== 16'h0000 || out_status[0] !== 1'b1)
      $display("FAIL single_negzero: got %h st %h want 0000 with zero bit", out_sum, out_status);
    else n_pass++;
    take_result();
  endtask

  task automatic test_backpressure();
    int unsigned st;
    logic [15:0] acc, z, d;
    logic [7:0]  sacc, s;
    acc = FP16_ZERO;
    sacc = '0;
    for (int i = 0; i < 3; i++) begin
      d = rand_fp16();
      ref_add(acc, d, z, s);
      acc = z;
      sacc = sacc | s;
      push_beat(d, i == 2, st);
    end
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== acc || out_count !== 11'd3 ||
          out_status !== sacc || out_len_err !== 1'b0)
        $display("FAIL bp_hold c%0d: got rdy %b vld %b %h/%0d/%h want 0 1 %h/3/%h",
                 c, in_ready, out_valid, out_sum, out_count, out_status, acc, sacc);
      else n_pass++;
      @(posedge clk); #1;
    end
    take_result();
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 11'd0)
      $display("FAIL bp_release: got rdy %b vld %b cnt %0d want 1 0 0", in_ready, out_valid, out_count);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int unsigned st;
    push_beat(16'h7BFF, 1'b0, st);
    push_beat(16'h7BFF, 1'b1, st);
    n_total++; if (out_sum !== 16'h7C00) $display("FAIL ovf_sum: got %h want 7c00", out_sum); else n_pass++;
    n_total++; if (out_status[1] !== 1'b1 || out_status[4] !== 1'b1 || out_status[7:6] !== 2'b00)
      $display("FAIL ovf_status: got %h want bits 1,4 set and 7:6 clear", out_status);
    else n_pass++;
    take_result();
  endtask

  task automatic test_reset_mid();
    int unsigned st;
    push_beat(FP16_ONE, 1'b0, st);
    push_beat(FP16_ONE, 1'b0, st);
    in_valid = 1'b1;
    in_data  = FP16_ONE;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    n_total++; if ({out_valid, out_sum, out_count, out_status, out_len_err} !== '0 || in_ready !== 1'b1)
      $display("FAIL midreset: got vld %b %h/%0d/%h/%b rdy %b want all 0, rdy 1",
               out_valid, out_sum, out_count, out_status, out_len_err, in_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) push_beat(FP16_ONE, i == 2, st);
    n_total++; if (out_sum !== 16'h4200 || out_count !== 11'd3)
      $display("FAIL midreset_fresh: got %h/%0d want 4200/3", out_sum, out_count);
    else n_pass++;
    take_result();
  endtask

  task automatic test_random();
    int unsigned st, len, gap;
    logic [15:0] acc, z, d;
    logic [7:0]  sacc, s;
    for (int v = 0; v < 25; v++) begin
      len = $urandom_range(1, 8);
      acc = FP16_ZERO;
      sacc = '0;
      for (int unsigned i = 0; i < len; i++) begin
        d = rand_fp16();
        ref_add(acc, d, z, s);
        acc = z;
        sacc = sacc | s;
        push_beat(d, i == len - 1, st);
      end
      n_total++;
      if (out_valid !== 1'b1 || out_sum !== acc || out_count !== 11'(len) ||
          out_status !== sacc || out_len_err !== 1'b0)
        $display("FAIL rand_v%0d: got vld %b %h/%0d/%h/%b want 1 %h/%0d/%h/0",
                 v, out_valid, out_sum, out_count, out_status, out_len_err, acc, len, sacc);
      else n_pass++;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    int unsigned st;
    out_ready = 1'b1;
    push_beat(FP16_ONE, 1'b0, st);
    push_beat(FP16_ONE, 1'b1, st);
    n_total++; if (out_valid !== 1'b1 || out_sum !== 16'h4000)
      $display("FAIL b2b_first: got vld %b sum %h want 1 4000", out_valid, out_sum);
    else n_pass++;
    push_beat(16'h3800, 1'b1, st);
    n_total++; if (st !== 1) $display("FAIL b2b_gap: got %0d stall cycles want 1", st); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || out_sum !== 16'h3800 || out_count !== 11'd1)
      $display("FAIL b2b_second: got vld %b %h/%0d want 1 3800/1", out_valid, out_sum, out_count);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_max_len();
    int unsigned st;
    for (int i = 0; i < 1024; i++) begin
      push_beat(16'h1400, 1'b0, st);
      if (i == 1022) begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL max_early: got vld %b at 1023 want 0", out_valid); else n_pass++;
      end
    end
    n_total++; if (out_valid !== 1'b1 || out_len_err !== 1'b1 || out_count !== 11'd1024 || out_sum !== FP16_ONE)
      $display("FAIL max1024: got vld %b err %b cnt %0d sum %h want 1 1 1024 3c00",
               out_valid, out_len_err, out_count, out_sum);
    else n_pass++;
    take_result();

    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = FP16_ONE;
      b_in_last  = 1'b0;
      n_total++; if (b_in_ready !== 1'b1) $display("FAIL max4_ready b%0d: got %b want 1", i, b_in_ready); else n_pass++;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    n_total++; if (b_out_valid !== 1'b1 || b_out_len_err !== 1'b1 || b_out_count !== 3'd4 || b_out_sum !== 16'h4400)
      $display("FAIL max4: got vld %b err %b cnt %0d sum %h want 1 1 4 4400",
               b_out_valid, b_out_len_err, b_out_count, b_out_sum);
    else n_pass++;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_in_last  = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    n_total++; if (b_out_valid !== 1'b1 || b_out_len_err !== 1'b0 || b_out_count !== 3'd1)
      $display("FAIL max4_next: got vld %b err %b cnt %0d want 1 0 1", b_out_valid, b_out_len_err, b_out_count);
    else n_pass++;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_four_ones();
    test_single();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_max_len();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
